// File: rtl/decode_stage_if.sv
// ID-stage bus: IF/ID slot, pipeline control, writeback port and the ID/EX register outputs.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            stall, flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            id_ready, id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rd;
  logic [2:0]      id_funct3;
  logic [7:0]      id_ctrl;
  logic            id_illegal;

  modport master (
    output if_valid, if_instr, if_pc, stall, flush, wb_en, wb_rd, wb_data,
    input  id_ready, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rd, id_funct3, id_ctrl, id_illegal
  );
  modport slave (
    input  if_valid, if_instr, if_pc, stall, flush, wb_en, wb_rd, wb_data,
    output id_ready, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rd, id_funct3, id_ctrl, id_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I/E decode stage: register file, immediate generation, control table,
// load-use interlock and the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [6:0] OP_R  = 7'b0110011, OP_I   = 7'b0010011, OP_LD  = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR  = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111;
  localparam int C_MR = 6;

  logic [XLEN-1:0] rf [NREGS];
  logic [31:0]     ins, imm32, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0]      rs1, rs2, rd, h_rs1, h_rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [7:0]      ctrl;
  logic            known, use1, use2, userd, illegal, hazard, wr_ok;

  function automatic logic in_rng(input logic [4:0] r);
    return int'(r) < NREGS;
  endfunction

  assign ins   = bus.if_instr;
  assign rs1   = ins[19:15];
  assign rs2   = ins[24:20];
  assign rd    = ins[11:7];
  assign wr_ok = bus.wb_en && (bus.wb_rd != 5'd0) && in_rng(bus.wb_rd);

  // Out-of-range sources read as zero; the instruction is flagged illegal anyway.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && in_rng(rs1))
      rs1_val = (BYPASS != 0 && wr_ok && bus.wb_rd == rs1) ? bus.wb_data : rf[rs1[AW-1:0]];
    if (rs2 != 5'd0 && in_rng(rs2))
      rs2_val = (BYPASS != 0 && wr_ok && bus.wb_rd == rs2) ? bus.wb_data : rf[rs2[AW-1:0]];
  end

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // ctrl = {RegWrite,MemRead,MemWrite,ALUSrc,Branch,MemtoReg,Jump,AUIPC}
  always_comb begin
    known = 1'b1;
    ctrl  = '0;
    imm32 = '0;
    use1  = 1'b0;
    use2  = 1'b0;
    userd = 1'b0;
    case (ins[6:0])
      OP_R:   begin ctrl = 8'h80; use1 = 1'b1; use2 = 1'b1; userd = 1'b1; end
      OP_I:   begin ctrl = 8'h90; imm32 = imm_i; use1 = 1'b1; userd = 1'b1; end
      OP_LD:  begin ctrl = 8'hD4; imm32 = imm_i; use1 = 1'b1; userd = 1'b1; end
      OP_ST:  begin ctrl = 8'h30; imm32 = imm_s; use1 = 1'b1; use2 = 1'b1; end
      OP_BR:  begin ctrl = 8'h08; imm32 = imm_b; use1 = 1'b1; use2 = 1'b1; end
      OP_JAL: begin ctrl = 8'h82; imm32 = imm_j; userd = 1'b1; end
      OP_JR:  begin ctrl = 8'h92; imm32 = imm_i; use1 = 1'b1; userd = 1'b1; end
      OP_LUI: begin ctrl = 8'h90; imm32 = imm_u; userd = 1'b1; end
      OP_AUI: begin ctrl = 8'h91; imm32 = imm_u; userd = 1'b1; end
      default: known = 1'b0;
    endcase
  end

  assign illegal = !known || (use1 && !in_rng(rs1)) || (use2 && !in_rng(rs2)) ||
                   (userd && !in_rng(rd));
  assign hazard  = bus.id_valid && bus.id_ctrl[C_MR] && (bus.id_rd != 5'd0) && bus.if_valid &&
                   ((use1 && rs1 == bus.id_rd) || (use2 && rs2 == bus.id_rd));
  assign bus.id_ready = !bus.stall && !bus.flush && !hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      bus.id_valid    <= 1'b0;
      bus.id_pc       <= '0;
      bus.id_rs1_data <= '0;
      bus.id_rs2_data <= '0;
      bus.id_imm      <= '0;
      bus.id_rd       <= '0;
      bus.id_funct3   <= '0;
      bus.id_ctrl     <= '0;
      bus.id_illegal  <= 1'b0;
      h_rs1           <= '0;
      h_rs2           <= '0;
    end else begin
      if (wr_ok) rf[bus.wb_rd[AW-1:0]] <= bus.wb_data;
      if (bus.flush) begin
        bus.id_valid   <= 1'b0;
        bus.id_ctrl    <= '0;
        bus.id_illegal <= 1'b0;
      end else if (bus.stall) begin
        // Held operands must track writebacks that land while EX is blocked.
        if (wr_ok && h_rs1 != 5'd0 && h_rs1 == bus.wb_rd) bus.id_rs1_data <= bus.wb_data;
        if (wr_ok && h_rs2 != 5'd0 && h_rs2 == bus.wb_rd) bus.id_rs2_data <= bus.wb_data;
      end else if (hazard) begin
        bus.id_valid   <= 1'b0;
        bus.id_ctrl    <= '0;
        bus.id_illegal <= 1'b0;
      end else begin
        bus.id_valid    <= bus.if_valid;
        bus.id_pc       <= bus.if_pc;
        bus.id_rs1_data <= rs1_val;
        bus.id_rs2_data <= rs2_val;
        bus.id_imm      <= XLEN'($signed(imm32));
        bus.id_rd       <= rd;
        bus.id_funct3   <= ins[14:12];
        bus.id_ctrl     <= (bus.if_valid && !illegal) ? ctrl : 8'h00;
        bus.id_illegal  <= bus.if_valid && illegal;
        h_rs1           <= rs1;
        h_rs2           <= rs2;
      end
    end
  end
endmodule
